redmule_z_writeback_buffer: RTL and testbench
=============================================

// Module: redmule_z_writeback_buffer
// PURPOSE
//  Output-side counterpart of the X input buffer. Collects one FP column slice per beat from the
//  datapath array (one element per array row) into a W x D register tile. When the tile is full it
//  drains row by row as DW-bit words, with byte strobes, to the streamer over a valid/ready port.
//  Sits between the array outputs and the Z store path of the streamer.
// PARAMETERS
//  DW        288                 width of one streamer word (bits)
//  FpFormat  fpnew_pkg::FP16     element format; BITW = fpnew_pkg::fp_width(FpFormat)
//  Width     redmule_pkg::ARRAY_WIDTH   number of array rows W (elements per fill beat)
//  (derived) BITW = fp_width(FpFormat); D = DW/BITW = elements per word; DW%BITW==0; BITW%8==0
// PORTS
//  clk_i         in   1             clock
//  rst_ni        in   1             reset, asynchronous, active-low
//  clear_i       in   1             synchronous clear, same effect as reset
//  rows_lftovr_i in   $clog2(W)+1   valid rows in this tile, 0 = W
//  cols_lftovr_i in   $clog2(D)+1   valid columns in this tile, 0 = D, values >D saturate to D
//  fill_valid_i  in   1             fill beat valid
//  fill_ready_o  out  1             buffer accepts a fill beat
//  z_i           in   [W-1:0][BITW-1:0]  column slice; z_i[w] is the element for row w
//  out_valid_o   out  1             drain word valid
//  out_ready_i   in   1             streamer accepts drain word
//  out_data_o    out  DW            row word; element c at bits [c*BITW +: BITW]
//  out_strb_o    out  DW/8          byte enables for out_data_o
//  empty_o       out  1             FILL state and no column loaded yet
//  full_o        out  1             DRAIN state
//  tile_done_o   out  1             one-cycle pulse: tile fully drained
// BEHAVIOUR
//  - Reset/clear: state=FILL, col_cnt=0, row_cnt=0, tile regs=0, latched limits=W/D.
//    Outputs: fill_ready_o=1, out_valid_o=0, empty_o=1, full_o=0, tile_done_o=0, out_strb_o=0.
//    clear_i has priority over all other events and aborts a drain mid-transfer. out_valid_o drops.
//  - Limits: row_lim = rows_lftovr_i?rows_lftovr_i:W; col_lim = min(cols_lftovr_i?cols_lftovr_i:D, D).
//    Both are latched on the first accepted fill beat of a tile (col_cnt==0). They are stable to tile end.
//  - FILL: fill_ready_o=1. On fill_valid_i&fill_ready_o, tile[w][col_cnt] <= z_i[w] for all w.
//    Then col_cnt++. The limit test uses the col_lim value being latched in the same cycle.
//    Beat accepted with col_cnt==col_lim-1: col_cnt<=0, state<=DRAIN.
//    out_valid_o is high the next cycle, so the last fill beat has a 1-cycle latency to the first word.
//  - DRAIN: fill_ready_o=0; out_valid_o=1; out_data_o=tile[row_cnt], columns >=col_lim forced to 0.
//    out_strb_o has the low col_lim*BITW/8 bits set and all other bits clear.
//    On out_valid_o&out_ready_i: row_cnt++. Handshake with row_cnt==row_lim-1: row_cnt<=0, state<=FILL.
//    That also clears the tile regs and registers tile_done_o=1 for the next cycle.
//    Rows >= row_lim are never emitted.
//  - Handshake: once out_valid_o is high, it and out_data_o/out_strb_o hold until accepted.
//    out_valid_o never depends combinationally on out_ready_i.
//    fill_ready_o depends only on state.
//  - tile_done_o is high in the first FILL cycle after a drain. A fill beat may be accepted in that same cycle.
//  - fill_valid_i during DRAIN is ignored (not accepted). Config input changes mid-tile have no effect.
//  - Counters: col_cnt is $clog2(D)+1 bits and row_cnt is $clog2(W)+1 bits. They never exceed limit-1 (no wrap).
// TESTING (bench: Width=4, DW=288, FP16 -> D=18, 36 strobe bytes)
//  1 Full tile: 18 beats, z_i[w]=16'h(w*256+c), then out_ready_i=1.
//    -> 4 words, word w elem c = w*256+c, strb all ones, tile_done_o pulses once, then empty_o=1.
//  2 Leftovers: rows=3, cols=5. 5 beats.
//    -> 3 words; strb=36'h0_0000_03FF; bits [287:80]=0; row 3 is never emitted.
//  3 Backpressure: out_ready_i low 7 cycles on word 1.
//    -> out_valid_o and out_data_o stay stable, fill_ready_o=0, and an asserted fill_valid_i is not consumed.
//  4 Back-to-back tiles: fill_valid_i held high continuously.
//    -> tile-2 beat 0 is accepted in the tile_done_o cycle, and tile-2 data has no tile-1 residue.
//  5 clear_i asserted during drain row 2.
//    -> next cycle out_valid_o=0, fill_ready_o=1, empty_o=1, tile regs=0, no tile_done_o pulse.
//  6 Async rst_ni pulse mid-fill (col_cnt=9).
//    -> outputs take reset values immediately, and a fresh 18-beat tile drains correctly.

Source files
------------

// File: rtl/redmule_z_writeback_buffer.sv
// Z writeback buffer: gathers one column slice per fill beat into a W x D tile, then
// drains the tile row by row as DW-bit words with byte strobes over a valid/ready port.
module redmule_z_writeback_buffer #(
    parameter int unsigned DW    = 288,
    parameter int unsigned BITW  = 16,
    parameter int unsigned Width = 4,
    localparam int unsigned D    = DW / BITW,
    localparam int unsigned RW   = $clog2(Width) + 1,
    localparam int unsigned CW   = $clog2(D) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic [RW-1:0]                   rows_lftovr_i,
    input  logic [CW-1:0]                   cols_lftovr_i,
    input  logic                            fill_valid_i,
    output logic                            fill_ready_o,
    input  logic [Width-1:0][BITW-1:0]      z_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DW-1:0]                   out_data_o,
    output logic [DW/8-1:0]                 out_strb_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic                            tile_done_o
);

    typedef enum logic {FILL, DRAIN} state_e;

    // Handshakes: a fill beat moves when fill_valid_i && fill_ready_o at a rising edge;
    // a drain word moves when out_valid_o && out_ready_i. Both ready/valid outputs come
    // from registered state only, so neither depends combinationally on its partner.
    state_e                     state_q;
    logic [CW-1:0]              col_cnt_q;
    logic [RW-1:0]              row_cnt_q;
    logic [CW-1:0]              col_lim_q;
    logic [RW-1:0]              row_lim_q;
    logic                       tile_done_q;
    logic [D-1:0][BITW-1:0]     tile_q [Width];

    logic [CW-1:0]              col_lim_in;
    logic [RW-1:0]              row_lim_in;
    logic [CW-1:0]              col_lim_eff;
    logic [D-1:0][BITW-1:0]     row_sel;
    int                         strb_bytes;

    always_comb begin
        col_lim_in = cols_lftovr_i;
        if (cols_lftovr_i == '0 || cols_lftovr_i > CW'(D)) col_lim_in = CW'(D);
        row_lim_in = rows_lftovr_i;
        if (rows_lftovr_i == '0 || rows_lftovr_i > RW'(Width)) row_lim_in = RW'(Width);
        // The first beat of a tile tests against the limit being latched in that same cycle.
        col_lim_eff = (col_cnt_q == '0) ? col_lim_in : col_lim_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            col_lim_q   <= CW'(D);
            row_lim_q   <= RW'(Width);
            tile_done_q <= 1'b0;
            for (int w = 0; w < Width; w++) tile_q[w] <= '0;
        end else if (clear_i) begin
            state_q     <= FILL;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            col_lim_q   <= CW'(D);
            row_lim_q   <= RW'(Width);
            tile_done_q <= 1'b0;
            for (int w = 0; w < Width; w++) tile_q[w] <= '0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (fill_valid_i) begin
                        for (int w = 0; w < Width; w++) begin
                            for (int c = 0; c < D; c++) begin
                                if (CW'(c) == col_cnt_q) tile_q[w][c] <= z_i[w];
                            end
                        end
                        if (col_cnt_q == '0) begin
                            col_lim_q <= col_lim_in;
                            row_lim_q <= row_lim_in;
                        end
                        if (col_cnt_q == col_lim_eff - CW'(1)) begin
                            col_cnt_q <= '0;
                            state_q   <= DRAIN;
                        end else begin
                            col_cnt_q <= col_cnt_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (row_cnt_q == row_lim_q - RW'(1)) begin
                            row_cnt_q   <= '0;
                            state_q     <= FILL;
                            tile_done_q <= 1'b1;
                            for (int w = 0; w < Width; w++) tile_q[w] <= '0;
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Word assembly is a pure function of registers, so it holds while a word waits.
    always_comb begin
        row_sel    = '0;
        out_data_o = '0;
        out_strb_o = '0;
        strb_bytes = int'(col_lim_q) * int'(BITW / 8);
        for (int r = 0; r < Width; r++) begin
            if (RW'(r) == row_cnt_q) row_sel = tile_q[r];
        end
        if (state_q == DRAIN) begin
            for (int c = 0; c < D; c++) begin
                if (CW'(c) < col_lim_q) out_data_o[c*BITW +: BITW] = row_sel[c];
            end
            for (int b = 0; b < DW / 8; b++) begin
                if (b < strb_bytes) out_strb_o[b] = 1'b1;
            end
        end
    end

    assign fill_ready_o = (state_q == FILL);
    assign out_valid_o  = (state_q == DRAIN);
    assign full_o       = (state_q == DRAIN);
    assign empty_o      = (state_q == FILL) && (col_cnt_q == '0);
    assign tile_done_o  = tile_done_q;

endmodule

// File: tb/tb_redmule_z_writeback_buffer.sv
// Bench for redmule_z_writeback_buffer: directed tiles, a queue model of expected drain
// words and tile_done pulses, and a per-cycle compare process on the falling edge.
module tb_redmule_z_writeback_buffer;

    localparam int DW   = 288;
    localparam int BITW = 16;
    localparam int W    = 4;
    localparam int D    = DW / BITW;
    localparam int SB   = DW / 8;
    localparam int RW   = $clog2(W) + 1;
    localparam int CW   = $clog2(D) + 1;
    localparam int EW   = 1 + SB + DW;

    logic                   clk_i;
    logic                   rst_ni;
    logic                   clear_i;
    logic [RW-1:0]          rows_lftovr_i;
    logic [CW-1:0]          cols_lftovr_i;
    logic                   fill_valid_i;
    logic                   fill_ready_o;
    logic [W-1:0][BITW-1:0] z_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DW-1:0]          out_data_o;
    logic [SB-1:0]          out_strb_o;
    logic                   empty_o;
    logic                   full_o;
    logic                   tile_done_o;

    redmule_z_writeback_buffer #(
        .DW    (DW),
        .BITW  (BITW),
        .Width (W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .rows_lftovr_i (rows_lftovr_i),
        .cols_lftovr_i (cols_lftovr_i),
        .fill_valid_i  (fill_valid_i),
        .fill_ready_o  (fill_ready_o),
        .z_i           (z_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_strb_o    (out_strb_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .tile_done_o   (tile_done_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];   // {last_row, strb, data}
    logic done_due = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic logic [BITW-1:0] pat(input int t, input int w, input int c);
        return BITW'(t * 4096 + w * 256 + c);
    endfunction

    // Every valid cycle the presented word must equal the queue head (also proves stability).
    always @(negedge clk_i) begin
        logic [EW-1:0] e;
        if (rst_ni) begin
            check("tile_done", DW'(tile_done_o), DW'(done_due));
            done_due = 1'b0;
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", DW'(out_valid_o), '0);
                end else begin
                    e = exp_q[0];
                    check("word_data", out_data_o, e[DW-1:0]);
                    check("word_strb", DW'(out_strb_o), DW'(e[DW +: SB]));
                    if (out_ready_i) begin
                        done_due = e[EW-1];
                        void'(exp_q.pop_front());
                    end
                end
            end
        end else begin
            done_due = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_fill_ready(output bit ok);
        int n = 0;
        @(negedge clk_i);
        while (!fill_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        ok = fill_ready_o;
        if (!ok) check("fill_ready_timeout", DW'(fill_ready_o), DW'(1));
    endtask

    // Drives nb beats (nb<0: whole tile); a completed tile pushes its expected words.
    task automatic fill_tile(input int t, input int rows, input int cols, input bit chk_first, input int nb);
        int rl, cl, beats;
        bit ok;
        logic [DW-1:0] data;
        logic [SB-1:0] strb;
        rows_lftovr_i = RW'(rows);
        cols_lftovr_i = CW'(cols);
        rl = (rows == 0) ? W : rows;
        cl = (cols == 0 || cols > D) ? D : cols;
        beats = (nb < 0) ? cl : nb;
        for (int c = 0; c < beats; c++) begin
            for (int w = 0; w < W; w++) z_i[w] = pat(t, w, c);
            fill_valid_i = 1'b1;
            wait_fill_ready(ok);
            if (chk_first && c == 0) check("beat0_in_done_cycle", DW'(tile_done_o), DW'(1));
            @(posedge clk_i);
            #1;
        end
        if (beats == cl) begin
            for (int r = 0; r < rl; r++) begin
                data = '0;
                strb = '0;
                for (int c = 0; c < cl; c++) data[c*BITW +: BITW] = pat(t, r, c);
                for (int b = 0; b < cl * (BITW / 8); b++) strb[b] = 1'b1;
                exp_q.push_back({(r == rl - 1), strb, data});
            end
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        @(negedge clk_i);
        #1;
        while ((exp_q.size() != 0 || out_valid_o) && n < 300) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", DW'(exp_q.size()), '0);
    endtask

    // ---------------- directed tests ----------------
    logic [DW-1:0] tmp;

    initial begin
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        rows_lftovr_i = '0;
        cols_lftovr_i = '0;
        fill_valid_i  = 1'b0;
        out_ready_i   = 1'b0;
        z_i           = '0;
        #3;
        check("rst_fill_ready", DW'(fill_ready_o), DW'(1));
        check("rst_out_valid", DW'(out_valid_o), '0);
        check("rst_empty", DW'(empty_o), DW'(1));
        check("rst_full", DW'(full_o), '0);
        check("rst_tile_done", DW'(tile_done_o), '0);
        check("rst_strb", DW'(out_strb_o), '0);
        #9 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: full tile, literal pins on word 0
        fill_tile(0, 0, 0, 1'b0, -1);
        fill_valid_i = 1'b0;
        @(negedge clk_i);
        check("t1_valid_latency", DW'(out_valid_o), DW'(1));
        check("t1_full", DW'(full_o), DW'(1));
        check("t1_fill_ready", DW'(fill_ready_o), '0);
        tmp = out_data_o;
        check("t1_w0_e0", DW'(tmp[15:0]), DW'(16'h0000));
        check("t1_w0_e17", DW'(tmp[17*16 +: 16]), DW'(16'h0011));
        check("t1_strb", DW'(out_strb_o), DW'(36'hF_FFFF_FFFF));
        out_ready_i = 1'b1;
        wait_drained();
        check("t1_empty_after", DW'(empty_o), DW'(1));
        out_ready_i = 1'b0;

        // 2: leftovers rows=3 cols=5
        @(posedge clk_i);
        #1;
        fill_tile(1, 3, 5, 1'b0, -1);
        fill_valid_i = 1'b0;
        @(negedge clk_i);
        check("t2_strb", DW'(out_strb_o), DW'(36'h0_0000_03FF));
        tmp = out_data_o;
        check("t2_high_zero", DW'(tmp[287:80]), '0);
        check("t2_w0_e4", DW'(tmp[4*16 +: 16]), DW'(16'h1004));
        out_ready_i = 1'b1;
        wait_drained();
        check("t2_empty_after", DW'(empty_o), DW'(1));
        out_ready_i = 1'b0;

        // 3: backpressure on word 1 with a fill beat offered during drain
        @(posedge clk_i);
        #1;
        fill_tile(4, 0, 0, 1'b0, -1);
        fill_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i  = 1'b0;
        fill_valid_i = 1'b1;
        for (int w = 0; w < W; w++) z_i[w] = 16'hDEAD;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            check("t3_fill_ready_low", DW'(fill_ready_o), '0);
            check("t3_valid_held", DW'(out_valid_o), DW'(1));
        end
        fill_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        wait_drained();
        check("t3_empty_after", DW'(empty_o), DW'(1));

        // 4: back-to-back tiles, fill_valid_i held high, second tile saturates cols
        @(posedge clk_i);
        #1;
        fill_tile(2, 0, 0, 1'b0, -1);
        fill_tile(3, 2, 31, 1'b1, -1);
        fill_valid_i = 1'b0;
        wait_drained();
        out_ready_i = 1'b0;

        // 5: clear during drain row 2
        @(posedge clk_i);
        #1;
        fill_tile(5, 0, 0, 1'b0, -1);
        fill_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        check("t5_row2_valid", DW'(out_valid_o), DW'(1));
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check("t5_valid_dropped", DW'(out_valid_o), '0);
        check("t5_fill_ready", DW'(fill_ready_o), DW'(1));
        check("t5_empty", DW'(empty_o), DW'(1));
        check("t5_strb", DW'(out_strb_o), '0);
        @(posedge clk_i);
        #1;
        fill_tile(6, 0, 3, 1'b0, -1);
        fill_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        wait_drained();
        out_ready_i = 1'b0;

        // 6: async reset mid-fill at col_cnt=9, then a fresh full tile
        @(posedge clk_i);
        #1;
        fill_tile(8, 0, 0, 1'b0, 9);
        fill_valid_i = 1'b0;
        check("t6_not_empty", DW'(empty_o), '0);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_empty", DW'(empty_o), DW'(1));
        check("t6_rst_fill_ready", DW'(fill_ready_o), DW'(1));
        check("t6_rst_valid", DW'(out_valid_o), '0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        fill_tile(7, 0, 0, 1'b0, -1);
        fill_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        wait_drained();
        check("t6_empty_after", DW'(empty_o), DW'(1));
        check("queue_empty_at_end", DW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
